ycbcr2rgb: RTL



---
 rtl/ycbcr2rgb_pkg.sv | 22 ++
 rtl/ycbcr2rgb_if.sv | 25 ++
 rtl/rgb_sat.sv | 22 ++
 rtl/ycbcr2rgb.sv | 124 ++++++++++++
 4 files changed

// File: rtl/ycbcr2rgb_pkg.sv
// Shared decoder constants: Q11.12 colour coefficients and converter state encoding.
package ycbcr2rgb_pkg;

   typedef logic [23:0] fp_t;

   localparam fp_t FP_1P0      = 24'h001000;
   localparam fp_t FP_128P5    = 24'h080800;
   localparam fp_t FP_1P402    = 24'h00166F;
   localparam fp_t FP_1P772    = 24'h001C5A;
   localparam fp_t FP_M0P34414 = 24'hFFFA7E;
   localparam fp_t FP_M0P71414 = 24'hFFF493;

   localparam logic [2:0] ST_Y0    = 3'd0;
   localparam logic [2:0] ST_CB0   = 3'd1;
   localparam logic [2:0] ST_CR0   = 3'd2;
   localparam logic [2:0] ST_G1    = 3'd3;
   localparam logic [2:0] ST_G2    = 3'd4;
   localparam logic [2:0] ST_OUT_R = 3'd5;
   localparam logic [2:0] ST_OUT_G = 3'd6;
   localparam logic [2:0] ST_OUT_B = 3'd7;

endpackage

// File: rtl/ycbcr2rgb_if.sv
// Converter bus: upstream byte handshake, external MAC operands/result, pixel byte output.
interface ycbcr2rgb_if;
   import ycbcr2rgb_pkg::*;

   logic [7:0] d_in;
   logic       ycc_valid;
   logic       ycc_ready;
   logic [7:0] mac_a;
   fp_t        mac_mult;
   fp_t        mac_acc;
   fp_t        mac_out;
   logic       d_qual;
   logic [7:0] dout;

   modport slave (
      input  d_in, ycc_valid, mac_out,
      output ycc_ready, mac_a, mac_mult, mac_acc, d_qual, dout
   );

   modport master (
      output d_in, ycc_valid, mac_out,
      input  ycc_ready, mac_a, mac_mult, mac_acc, d_qual, dout
   );

endinterface

// File: rtl/rgb_sat.sv
// Q11.12 to 8-bit pixel byte: clamp to 0..255, or raw fraction-truncated bits when SAT_EN=0.
module rgb_sat
   import ycbcr2rgb_pkg::*;
#(
   parameter bit SAT_EN = 1'b1
) (
   input  fp_t        i_x,
   output logic [7:0] o_y
);

   always_comb begin
      o_y = i_x[19:12];
      if (SAT_EN) begin
         if (i_x[23]) begin
            o_y = 8'h00;
         end else if (|i_x[22:20]) begin
            o_y = 8'hFF;
         end
      end
   end

endmodule

// File: rtl/ycbcr2rgb.sv
// Serial YCbCr -> RGB converter; time-shares the decoder's external MAC, emits R, G, B bytes.
module ycbcr2rgb
   import ycbcr2rgb_pkg::*;
#(
   parameter bit SAT_EN = 1'b1
) (
   input  logic         clk_in,
   input  logic         rst_n,
   ycbcr2rgb_if.slave   bus
);

   logic [2:0] r_state;
   fp_t        r_y, r_r, r_g, r_b;
   logic [7:0] r_cb, r_cr;

   logic       w_ready, w_xfer, w_qual;
   logic [7:0] w_mac_a;
   fp_t        w_mac_mult, w_mac_acc, w_sat_src;
   logic [7:0] w_sat_out;

   assign w_ready = (r_state == ST_Y0) | (r_state == ST_CB0) | (r_state == ST_CR0);
   assign w_xfer  = w_ready & bus.ycc_valid;
   assign w_qual  = (r_state == ST_OUT_R) | (r_state == ST_OUT_G) | (r_state == ST_OUT_B);

   // MAC operands stay zero unless this cycle actually performs an accumulate
   always_comb begin
      w_mac_a    = '0;
      w_mac_mult = '0;
      w_mac_acc  = '0;
      case (r_state)
         ST_Y0: if (w_xfer) begin
            w_mac_a    = bus.d_in;
            w_mac_mult = FP_1P0;
            w_mac_acc  = FP_128P5;
         end
         ST_CB0: if (w_xfer) begin
            w_mac_a    = bus.d_in;
            w_mac_mult = FP_1P772;
            w_mac_acc  = r_y;
         end
         ST_CR0: if (w_xfer) begin
            w_mac_a    = bus.d_in;
            w_mac_mult = FP_1P402;
            w_mac_acc  = r_y;
         end
         ST_G1: begin
            w_mac_a    = r_cb;
            w_mac_mult = FP_M0P34414;
            w_mac_acc  = r_y;
         end
         ST_G2: begin
            w_mac_a    = r_cr;
            w_mac_mult = FP_M0P71414;
            w_mac_acc  = r_g;
         end
         default: ;
      endcase
   end

   always_comb begin
      w_sat_src = '0;
      case (r_state)
         ST_OUT_R: w_sat_src = r_r;
         ST_OUT_G: w_sat_src = r_g;
         ST_OUT_B: w_sat_src = r_b;
         default:  ;
      endcase
   end

   rgb_sat #(
      .SAT_EN (SAT_EN)
   ) u_sat (
      .i_x (w_sat_src),
      .o_y (w_sat_out)
   );

   always_ff @(posedge clk_in or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= ST_Y0;
         r_y     <= '0;
         r_r     <= '0;
         r_g     <= '0;
         r_b     <= '0;
         r_cb    <= '0;
         r_cr    <= '0;
      end else begin
         case (r_state)
            ST_Y0: if (w_xfer) begin
               r_y     <= bus.mac_out;
               r_state <= ST_CB0;
            end
            ST_CB0: if (w_xfer) begin
               r_cb    <= bus.d_in;
               r_b     <= bus.mac_out;
               r_state <= ST_CR0;
            end
            ST_CR0: if (w_xfer) begin
               r_cr    <= bus.d_in;
               r_r     <= bus.mac_out;
               r_state <= ST_G1;
            end
            ST_G1: begin
               r_g     <= bus.mac_out;
               r_state <= ST_G2;
            end
            ST_G2: begin
               r_g     <= bus.mac_out;
               r_state <= ST_OUT_R;
            end
            ST_OUT_R: r_state <= ST_OUT_G;
            ST_OUT_G: r_state <= ST_OUT_B;
            default:  r_state <= ST_Y0;
         endcase
      end
   end

   assign bus.ycc_ready = w_ready;
   assign bus.mac_a     = w_mac_a;
   assign bus.mac_mult  = w_mac_mult;
   assign bus.mac_acc   = w_mac_acc;
   assign bus.d_qual    = w_qual;
   assign bus.dout      = w_qual ? w_sat_out : 8'h00;

endmodule
